// File: rtl/fp_add_pkg.sv
// fp_add_pkg: shared widths and field positions for the small-float adder arbiter
package fp_add_pkg;
  localparam int EXP_W = 3;
  localparam int MAN_W = 2;
  localparam int FP_W = 1 + EXP_W + MAN_W;
  localparam int SIGN_BIT = FP_W - 1;
  localparam int EXP_HI = FP_W - 2;
  localparam int EXP_LO = MAN_W;
  localparam int MAN_HI = MAN_W - 1;
  localparam int MAN_LO = 0;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
endpackage

// File: rtl/fp6_add.sv
// fp6_add: combinational magnitude-only float adder, larger exponent sets sign and alignment
module fp6_add import fp_add_pkg::*; #(
  parameter int EXP_W = fp_add_pkg::EXP_W,
  parameter int MAN_W = fp_add_pkg::MAN_W,
  localparam int FP_W = 1 + EXP_W + MAN_W
) (
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] sum
);
  logic [EXP_W-1:0] ea, eb, e_big, e_sml, diff, e_out;
  logic [MAN_W:0] m_big, m_sml;
  logic [MAN_W+1:0] s;
  logic a_big, s_big, carry, sub_up;
  logic [MAN_W-1:0] m_out;
  assign ea = a[MAN_W +: EXP_W];
  assign eb = b[MAN_W +: EXP_W];
  // ties go to a so equal exponents take a's sign
  assign a_big = ea >= eb;
  assign e_big = a_big ? ea : eb;
  assign e_sml = a_big ? eb : ea;
  assign s_big = a_big ? a[FP_W-1] : b[FP_W-1];
  assign m_big = a_big ? {|ea, a[MAN_W-1:0]} : {|eb, b[MAN_W-1:0]};
  assign m_sml = a_big ? {|eb, b[MAN_W-1:0]} : {|ea, a[MAN_W-1:0]};
  assign diff = e_big - e_sml;
  assign s = {1'b0, m_big} + {1'b0, m_sml >> diff};
  assign carry = s[MAN_W+1];
  assign sub_up = (e_big == '0) & s[MAN_W];
  assign e_out = e_big + {{(EXP_W-1){1'b0}}, carry | sub_up};
  assign m_out = carry ? s[MAN_W:1] : s[MAN_W-1:0];
  assign sum = {s_big, e_out, m_out};
endmodule

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin share of one float adder between two requesters,
// with a single registered result stage and inf/nan classification.
module fp_add_arbiter import fp_add_pkg::*; #(
  parameter int EXP_W = fp_add_pkg::EXP_W,
  parameter int MAN_W = fp_add_pkg::MAN_W,
  localparam int FP_W = 1 + EXP_W + MAN_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [FP_W-1:0] req0_a,
  input  logic [FP_W-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [FP_W-1:0] req1_a,
  input  logic [FP_W-1:0] req1_b,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [FP_W-1:0] res_data,
  output logic            res_id,
  output logic            res_inf,
  output logic            res_nan
);
  logic last, g0, g1, space, xfer, inf_n, nan_n;
  logic [FP_W-1:0] op_a, op_b, sum;
  logic [EXP_W-1:0] e_n;
  assign g0 = req0_valid & (!req1_valid | last);
  assign g1 = req1_valid & (!req0_valid | !last);
  assign space = !res_valid | res_ready;
  assign req0_ready = rst_n & g0 & space;
  assign req1_ready = rst_n & g1 & space;
  assign xfer = (req0_ready & req0_valid) | (req1_ready & req1_valid);
  assign op_a = g1 ? req1_a : req0_a;
  assign op_b = g1 ? req1_b : req0_b;
  fp6_add #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_add (.a(op_a), .b(op_b), .sum(sum));
  assign e_n = sum[MAN_W +: EXP_W];
  assign inf_n = (e_n == '1) & (sum[MAN_W-1:0] == '0);
  assign nan_n = (e_n == '1) & (sum[MAN_W-1:0] != '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data <= '0;
      res_id <= 1'b0;
      res_inf <= 1'b0;
      res_nan <= 1'b0;
      last <= 1'b1;
    end else if (xfer) begin
      res_valid <= 1'b1;
      res_data <= sum;
      res_id <= g1;
      res_inf <= inf_n;
      res_nan <= nan_n;
      last <= g1;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: directed checks of arithmetic, round-robin, backpressure and reset
module tb_fp_add_arbiter;
  logic clk = 0, rst_n = 0;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [5:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic res_valid, res_ready = 1, res_id, res_inf, res_nan;
  logic [5:0] res_data;
  int checks = 0, failures = 0;
  localparam logic [5:0] C0 = 6'b0_010_00, C1 = 6'b0_011_00;
  fp_add_arbiter dut (.clk(clk), .rst_n(rst_n), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .res_inf(res_inf), .res_nan(res_nan));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic one(input string tag, input logic [5:0] a, input logic [5:0] b,
                     input logic [5:0] exp, input logic inf, input logic nan);
    req1_a = a;
    req1_b = b;
    req1_valid = 1;
    #1;
    chk({tag, "_rdy"}, req1_ready, 1);
    tick();
    req1_valid = 0;
    chk({tag, "_vld"}, res_valid, 1);
    chk({tag, "_data"}, res_data, exp);
    chk({tag, "_id"}, res_id, 1);
    chk({tag, "_inf"}, res_inf, inf);
    chk({tag, "_nan"}, res_nan, nan);
    tick();
  endtask
  initial begin
    req0_valid = 1;
    req1_valid = 1;
    #12;
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 0);
    chk("rst_id", res_id, 0);
    chk("rst_flags", {res_inf, res_nan}, 0);
    chk("rst_rdy", {req0_ready, req1_ready}, 0);
    req0_valid = 0;
    req1_valid = 0;
    rst_n = 1;
    tick();
    req0_a = 6'b0_011_01;
    req0_b = 6'b0_001_10;
    req0_valid = 1;
    #1;
    chk("single_rdy", {req0_ready, req1_ready}, 2'b10);
    tick();
    req0_valid = 0;
    chk("single_vld", res_valid, 1);
    chk("single_data", res_data, 6'b0_011_10);
    chk("single_id", res_id, 0);
    chk("single_flags", {res_inf, res_nan}, 0);
    tick();
    chk("drain_empty", res_valid, 0);
    one("ovf_inf", 6'b0_110_00, 6'b0_110_00, 6'b0_111_00, 1, 0);
    one("ovf_nan", 6'b0_110_11, 6'b0_110_11, 6'b0_111_11, 0, 1);
    one("subn", 6'b0_000_11, 6'b0_000_01, 6'b0_001_00, 0, 0);
    one("sign_a", 6'b1_011_01, 6'b0_001_10, 6'b1_011_10, 0, 0);
    one("tie_a", 6'b1_010_01, 6'b0_010_10, 6'b1_011_01, 0, 0);
    one("b_big", 6'b0_001_11, 6'b1_100_00, 6'b1_100_00, 0, 0);
    one("exp_wrap", 6'b0_111_00, 6'b0_111_00, 6'b0_000_00, 0, 0);
    #2 rst_n = 0;
    #2 rst_n = 1;
    tick();
    req0_a = 6'b0_001_00; req0_b = 6'b0_001_00;
    req1_a = 6'b0_011_00; req1_b = 6'b0_000_00;
    req0_valid = 1;
    req1_valid = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_rdy%0d", i), {req0_ready, req1_ready}, (i % 2) ? 2'b01 : 2'b10);
      tick();
      chk($sformatf("rr_vld%0d", i), res_valid, 1);
      chk($sformatf("rr_id%0d", i), res_id, i % 2);
      chk($sformatf("rr_data%0d", i), res_data, (i % 2) ? C1 : C0);
    end
    res_ready = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("bp_rdy%0d", i), {req0_ready, req1_ready}, 0);
      tick();
      chk($sformatf("bp_vld%0d", i), res_valid, 1);
      chk($sformatf("bp_data%0d", i), res_data, C1);
      chk($sformatf("bp_id%0d", i), res_id, 1);
    end
    res_ready = 1;
    #1;
    chk("rel_rdy", {req0_ready, req1_ready}, 2'b10);
    tick();
    req0_valid = 0;
    req1_valid = 0;
    chk("rel_id", res_id, 0);
    chk("rel_data", res_data, C0);
    tick();
    chk("rel_empty", res_valid, 0);
    req0_a = 6'b0_101_00; req0_b = 6'b0_101_00;
    req0_valid = 1;
    res_ready = 0;
    tick();
    req0_valid = 0;
    chk("pend_vld", res_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("async_vld", res_valid, 0);
    chk("async_data", res_data, 0);
    req0_a = 6'b0_001_00; req0_b = 6'b0_001_00;
    req0_valid = 1;
    req1_valid = 1;
    res_ready = 1;
    #1;
    chk("async_rdy", {req0_ready, req1_ready}, 0);
    tick();
    chk("held_vld", res_valid, 0);
    rst_n = 1;
    #1;
    chk("post_rdy", {req0_ready, req1_ready}, 2'b10);
    tick();
    req0_valid = 0;
    req1_valid = 0;
    chk("post_id", res_id, 0);
    chk("post_data", res_data, C0);
    tick();
    chk("post_empty", res_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
